// File: rtl/uart_frame_parser_pkg.sv
// rtl/uart_frame_parser_pkg.sv - shared types and constants for the UART frame parser
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-in / payload-and-result-out bundle of the frame parser
interface uart_frame_parser_if;

    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_Data_DV;
    logic [7:0] o_Data_Byte;
    logic       o_Frame_OK;
    logic       o_Frame_Err;
    logic [1:0] o_Err_Code;
    logic       o_Busy;

    modport slave (
        input  i_RX_DV,
        input  i_RX_Byte,
        output o_Data_DV,
        output o_Data_Byte,
        output o_Frame_OK,
        output o_Frame_Err,
        output o_Err_Code,
        output o_Busy
    );

    modport master (
        output i_RX_DV,
        output i_RX_Byte,
        input  o_Data_DV,
        input  o_Data_Byte,
        input  o_Frame_OK,
        input  o_Frame_Err,
        input  o_Err_Code,
        input  o_Busy
    );

endinterface

// File: rtl/uart_frame_parser_timeout.sv
// rtl/uart_frame_parser_timeout.sv - inter-byte idle timer, expires after TIMEOUT_CLKS idle clocks
module frame_timeout #(
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero while disabled so every frame starts from a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - sync hunt, length/checksum validation and cut-through payload output
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic               i_Clock,
    input  logic               i_Rst_L,
    uart_frame_parser_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_n;

    // Assertion is immediate; release is retimed onto the clock.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] len_q,       len_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [7:0]       sum_q,       sum_d;
    logic             data_dv_q,   data_dv_d;
    logic [7:0]       data_byte_q, data_byte_d;
    logic             ok_q,        ok_d;
    logic             err_q,       err_d;
    logic [1:0]       err_code_q,  err_code_d;

    logic             busy;
    logic             tmr_expire;
    logic [IDX_W-1:0] idx_inc;

    assign busy    = (state_q != ST_HUNT);
    assign idx_inc = idx_q + IDX_W'(1);

    frame_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk      (i_Clock),
        .rst_n    (rst_n),
        .enable_i (busy),
        .clear_i  (bus.i_RX_DV),
        .expire_o (tmr_expire)
    );

    // A byte strobe takes priority over a simultaneous timer expiry.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        data_dv_d   = 1'b0;
        data_byte_d = data_byte_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        if (bus.i_RX_DV) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.i_RX_Byte == SYNC_BYTE) begin
                        state_d = ST_LEN;
                        sum_d   = '0;
                        idx_d   = '0;
                    end
                end
                ST_LEN: begin
                    if ((bus.i_RX_Byte == 8'd0) || (bus.i_RX_Byte > MAX_LEN_B)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_HUNT;
                    end else begin
                        len_d   = bus.i_RX_Byte[IDX_W-1:0];
                        sum_d   = bus.i_RX_Byte;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    data_dv_d   = 1'b1;
                    data_byte_d = bus.i_RX_Byte;
                    sum_d       = sum_q + bus.i_RX_Byte;
                    idx_d       = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.i_RX_Byte == sum_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else if (tmr_expire) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_HUNT;
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            data_dv_q   <= 1'b0;
            data_byte_q <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            data_dv_q   <= data_dv_d;
            data_byte_q <= data_byte_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.o_Data_DV   = data_dv_q;
    assign bus.o_Data_Byte = data_byte_q;
    assign bus.o_Frame_OK  = ok_q;
    assign bus.o_Frame_Err = err_q;
    assign bus.o_Err_Code  = err_code_q;
    assign bus.o_Busy      = busy;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser with directed frames
module tb_uart_frame_parser;

    localparam int T  = 8680;
    localparam int NO = -1;
    localparam int DT = 0;
    localparam int OK = 1;
    localparam int ER = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .SYNC_BYTE    (8'hA5),
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (T)
    ) dut (
        .i_Clock (clk),
        .i_Rst_L (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected entries carry the cycle on which the pulse must be visible.
    always @(negedge clk) begin : monitor
        int   k;
        int   v;
        exp_t e;
        if (bus.o_Data_DV || bus.o_Frame_OK || bus.o_Frame_Err) begin
            k = bus.o_Data_DV ? DT : (bus.o_Frame_OK ? OK : ER);
            v = bus.o_Data_DV ? int'(bus.o_Data_Byte) :
                (bus.o_Frame_Err ? int'(bus.o_Err_Code) : 0);
            check("ok_err_exclusive", int'(bus.o_Frame_OK & bus.o_Frame_Err), 0);
            if (q.size() == 0) begin
                check("unexpected_event_kind", k, NO);
            end else begin
                e = q.pop_front();
                check("event_kind", k, e.kind);
                check("event_value", v, e.val);
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    // Entered and left on a negedge; gap is the number of idle cycles that follow.
    task automatic send(input logic [7:0] b, input int kind, input int val, input int gap);
        if (kind != NO) q.push_back('{kind, val, cyc + 1});
        bus.i_RX_Byte = b;
        bus.i_RX_DV   = 1'b1;
        last_edge     = cyc + 1;
        @(negedge clk);
        bus.i_RX_DV = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.o_Busy), 0);
        check("rst_data_byte", int'(bus.o_Data_Byte), 0);
        check("rst_err_code", int'(bus.o_Err_Code), 0);
        check("rst_pulses", int'({bus.o_Data_DV, bus.o_Frame_OK, bus.o_Frame_Err}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // good frame
        send(8'hA5, NO, 0, 2);
        check("busy_after_sync", int'(bus.o_Busy), 1);
        send(8'h03, NO, 0, 2);
        send(8'h11, DT, 8'h11, 2);
        send(8'h22, DT, 8'h22, 2);
        send(8'h33, DT, 8'h33, 2);
        send(8'h69, OK, 0, 3);
        check("code_after_ok", int'(bus.o_Err_Code), 0);
        check("idle_after_ok", int'(bus.o_Busy), 0);

        // leading noise and checksum wrap
        send(8'h00, NO, 0, 2);
        send(8'hFF, NO, 0, 2);
        check("noise_ignored", int'(bus.o_Busy), 0);
        send(8'hA5, NO, 0, 2);
        send(8'h02, NO, 0, 2);
        send(8'hFF, DT, 8'hFF, 2);
        send(8'h02, DT, 8'h02, 2);
        send(8'h03, OK, 0, 3);

        // bad lengths: zero and MAX_LEN+1
        send(8'hA5, NO, 0, 2);
        send(8'h00, ER, 1, 2);
        send(8'hA5, NO, 0, 2);
        send(8'h11, ER, 1, 2);
        check("idle_after_len_err", int'(bus.o_Busy), 0);

        // sync value inside payload is data; checksum mismatch
        send(8'hA5, NO, 0, 2);
        send(8'h01, NO, 0, 2);
        send(8'hA5, DT, 8'hA5, 2);
        send(8'h00, ER, 2, 3);
        check("code_held_chk", int'(bus.o_Err_Code), 2);

        // stalled frame times out
        send(8'hA5, NO, 0, 2);
        send(8'h02, NO, 0, 2);
        send(8'h10, DT, 8'h10, 0);
        q.push_back('{ER, 3, last_edge + T});
        repeat (T + 4) @(negedge clk);
        check("timeout_seen", q.size(), 0);
        check("idle_after_timeout", int'(bus.o_Busy), 0);

        send(8'hA5, NO, 0, 2);
        send(8'h01, NO, 0, 2);
        send(8'h07, DT, 8'h07, 2);
        send(8'h08, OK, 0, 3);

        // byte on the expiry cycle keeps the frame alive
        send(8'hA5, NO, 0, 2);
        send(8'h02, NO, 0, 2);
        send(8'h10, DT, 8'h10, T - 1);
        send(8'h20, DT, 8'h20, 2);
        send(8'h32, OK, 0, 3);
        check("code_held_after_ok", int'(bus.o_Err_Code), 3);

        // maximum length, bytes back-to-back
        send(8'hA5, NO, 0, 0);
        send(8'h10, NO, 0, 0);
        for (int i = 1; i <= 16; i++) send(8'(i), DT, i, 0);
        send(8'h98, OK, 0, 3);

        // reset mid-frame
        send(8'hA5, NO, 0, 2);
        send(8'h02, NO, 0, 2);
        send(8'h10, DT, 8'h10, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.o_Busy), 0);
        check("midrst_err_code", int'(bus.o_Err_Code), 0);
        check("midrst_data_byte", int'(bus.o_Data_Byte), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'hA5, NO, 0, 2);
        send(8'h01, NO, 0, 2);
        send(8'h07, DT, 8'h07, 2);
        send(8'h08, OK, 0, 5);

        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame decoder sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes, hunts for a sync byte, and validates a length-prefixed frame with an 8-bit additive checksum. Payload bytes stream out cut-through as they arrive, and a single result pulse (OK or error) closes every frame. An inter-byte timeout aborts frames stalled mid-reception.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_LEN, 16, largest legal payload length (1..255)
- TIMEOUT_CLKS, 8680, idle clocks tolerated between bytes inside a frame (4 byte-times at 217 clks/bit)
- i_Clock  in  1  sole clock
- i_Rst_L  in  1  reset; asynchronous, active-low
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid
- i_RX_Byte  in  8  received byte
- o_Data_DV  out  1  one-cycle strobe: o_Data_Byte is a payload byte
- o_Data_Byte  out  8  payload byte; holds last value
- o_Frame_OK  out  1  one-cycle pulse: frame passed checksum
- o_Frame_Err  out  1  one-cycle pulse: frame aborted
- o_Err_Code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout; updated with o_Frame_Err, held until next o_Frame_Err or reset
- o_Busy  out  1  high in any state other than HUNT

## Operation
- Frame: SYNC, LEN, LEN payload bytes, CHK. CHK must equal (LEN + sum of payload) mod 256.
- States: HUNT, LEN, PAYLOAD, CHECK.
- HUNT: bytes other than SYNC_BYTE are ignored silently. SYNC_BYTE -> LEN; clear the sum and index.
- LEN: if the byte is 0 or > MAX_LEN -> pulse Err, code 1, go to HUNT. Otherwise store the length, sum = byte, go to PAYLOAD.
- PAYLOAD: each byte is emitted on o_Data_DV/o_Data_Byte and added to the sum (8-bit wrap). The index counter ($clog2(MAX_LEN+1) bits) increments per byte. After the LENth byte -> CHECK.
- CHECK: byte == sum -> pulse OK. Otherwise pulse Err with code 2. Both paths -> HUNT.
- SYNC_BYTE inside LEN, PAYLOAD, or CHECK is treated as data, not resync.
- Timeout: the counter clears on entering LEN and on every i_RX_DV. It counts while o_Busy is high. On reaching TIMEOUT_CLKS-1 without a byte -> pulse Err, code 3, go to HUNT, with no further o_Data_DV.
- A byte strobe on the same cycle as timeout expiry wins: the byte is processed and the timer clears.
- OK and Err are mutually exclusive and never both asserted.

## Timing
- Reset (async assert, sync-safe deassert inside the block): all outputs 0, o_Err_Code 0, state HUNT, counters 0.
- Reset mid-frame abandons the frame with no OK or Err pulse.
- o_Data_DV is asserted exactly 1 cycle after the corresponding i_RX_DV.
- OK and Err for length and checksum errors are asserted 1 cycle after the offending i_RX_DV.
- Timeout Err is asserted 1 cycle after the counter hits TIMEOUT_CLKS-1.
- Back-to-back i_RX_DV on consecutive cycles must be accepted with no byte lost, though the upstream receiver never produces this.
- A new SYNC is accepted on the cycle after the result pulse, because the state is already HUNT.

## Structure
- Package uart_frame_pkg holds:
  - state encoding: HUNT, LEN, PAYLOAD, CHECK
  - error code constants: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT
  - default SYNC_BYTE
- Sub-module frame_timeout holds the inter-byte timer:
  - inputs: enable, clear
  - output: one-cycle expire
  - width: $clog2(TIMEOUT_CLKS)
- All other logic stays in the parser.

## Test plan
- Good frame: A5 03 11 22 33 69 -> o_Data_DV ×3 with bytes 11, 22, 33, then one o_Frame_OK, o_Err_Code stays 0.
- Sum wrap and leading noise: 00 FF A5 02 FF 02 03 -> noise ignored, data FF then 02, o_Frame_OK.
- Bad length: A5 00 -> Err code 1. Then A5 11 with MAX_LEN=16 -> Err code 1. No o_Data_DV in either case.
- Bad checksum: A5 01 A5 00 -> one data byte A5 (A5 treated as data), Err code 2.
- Timeout: A5 02 10, then silence for TIMEOUT_CLKS cycles -> Err code 3. Next, A5 01 07 08 -> OK. A byte arriving exactly at expiry -> no Err.
- Reset asserted after A5 02 10 -> outputs 0, no pulses. After release, A5 01 07 08 -> OK.
